// File: rtl/escalonador_necessidades.sv
// Periodic need scheduler: divides clk into a tick and, on each tick, runs one
// update pass over fome, sono and felicidade through a single shared saturating
// add/sub unit. Death is declared when any counter reaches zero and is sticky.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ESPERA    | idle, waiting for a tick (ticks ignored once morto=1)
// ATU_FOME  | shared unit writes fome
// ATU_SONO  | shared unit writes sono
// ATU_FELIC | shared unit writes felicidade
// VERIFICA  | death check, atualizado pulse
module escalonador_necessidades #(
    parameter int CLK_HZ        = 100,
    parameter int VALOR_INICIAL = 200,
    parameter int STAT_MAX      = 255,
    parameter int GANHO         = 5,
    parameter int DECAIMENTO    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] estado,
    output logic [7:0] fome,
    output logic [7:0] sono,
    output logic [7:0] felicidade,
    output logic       morto,
    output logic       ocupado,
    output logic       atualizado
);

    localparam int              PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRESC_FIM = PW'(CLK_HZ - 1);
    localparam logic [8:0]      MAX9      = 9'(STAT_MAX);
    localparam logic [8:0]      GANHO9    = 9'(GANHO);
    localparam logic [8:0]      DEC9      = 9'(DECAIMENTO);
    localparam logic [7:0]      INI8      = 8'(VALOR_INICIAL);

    typedef enum logic [2:0] {
        ESPERA    = 3'd0,
        ATU_FOME  = 3'd1,
        ATU_SONO  = 3'd2,
        ATU_FELIC = 3'd3,
        VERIFICA  = 3'd4
    } estado_fsm_t;

    estado_fsm_t   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    est_q, est_d;
    logic [7:0]    fome_q, fome_d;
    logic [7:0]    sono_q, sono_d;
    logic [7:0]    felic_q, felic_d;
    logic          morto_q, morto_d;
    logic          tick;

    logic [7:0]    operando;
    logic          ganha;
    logic [8:0]    soma;
    logic [8:0]    dif;
    logic [7:0]    resultado;

    // Free-running prescaler; keeps counting during a pass.
    always_comb begin
        tick    = (presc_q == PRESC_FIM);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Shared saturating add/sub unit; operand and direction follow the FSM state.
    always_comb begin
        operando = fome_q;
        ganha    = (est_q == 3'b001);
        case (state_q)
            ATU_SONO: begin
                operando = sono_q;
                ganha    = (est_q == 3'b010);
            end
            ATU_FELIC: begin
                operando = felic_q;
                ganha    = (est_q == 3'b011);
            end
            default: begin
                operando = fome_q;
                ganha    = (est_q == 3'b001);
            end
        endcase
        soma = {1'b0, operando} + GANHO9;
        dif  = {1'b0, operando} - DEC9;
        if (ganha) begin
            resultado = (soma > MAX9) ? MAX9[7:0] : soma[7:0];
        end else begin
            resultado = ({1'b0, operando} < DEC9) ? 8'd0 : dif[7:0];
        end
    end

    // Next-state, counter writes and status outputs.
    always_comb begin
        state_d    = state_q;
        est_d      = est_q;
        fome_d     = fome_q;
        sono_d     = sono_q;
        felic_d    = felic_q;
        morto_d    = morto_q;
        ocupado    = (state_q != ESPERA);
        atualizado = (state_q == VERIFICA);
        case (state_q)
            ESPERA: begin
                if (tick && !morto_q) begin
                    est_d   = estado;
                    state_d = ATU_FOME;
                end
            end
            ATU_FOME: begin
                fome_d  = resultado;
                state_d = ATU_SONO;
            end
            ATU_SONO: begin
                sono_d  = resultado;
                state_d = ATU_FELIC;
            end
            ATU_FELIC: begin
                felic_d = resultado;
                state_d = VERIFICA;
            end
            VERIFICA: begin
                if ((fome_q == 8'd0) || (sono_q == 8'd0) || (felic_q == 8'd0)) begin
                    morto_d = 1'b1;
                end
                state_d = ESPERA;
            end
            default: state_d = ESPERA;
        endcase
    end

    // State register; reset discards any pass in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ESPERA;
            presc_q <= '0;
            est_q   <= 3'b000;
            fome_q  <= INI8;
            sono_q  <= INI8;
            felic_q <= INI8;
            morto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            est_q   <= est_d;
            fome_q  <= fome_d;
            sono_q  <= sono_d;
            felic_q <= felic_d;
            morto_q <= morto_d;
        end
    end

    assign fome       = fome_q;
    assign sono       = sono_q;
    assign felicidade = felic_q;
    assign morto      = morto_q;

endmodule

// File: tb/tb_escalonador_necessidades.sv
// Bench for escalonador_necessidades: a default-parameter instance checked with a
// scoreboard, plus two small instances for saturation and death.
module tb_escalonador_necessidades;

    localparam int CLK0 = 100;
    localparam int CLKS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [2:0] est0 = 3'b000, est1 = 3'b000, est2 = 3'b000;
    logic [7:0] fome0, sono0, felic0, fome1, sono1, felic1, fome2, sono2, felic2;
    logic       morto0, ocup0, atu0, morto1, ocup1, atu1, morto2, ocup2, atu2;

    escalonador_necessidades #(.CLK_HZ(CLK0)) u0 (
        .clk(clk), .rst(rst0), .estado(est0), .fome(fome0), .sono(sono0),
        .felicidade(felic0), .morto(morto0), .ocupado(ocup0), .atualizado(atu0));

    escalonador_necessidades #(.CLK_HZ(CLKS), .VALOR_INICIAL(253)) u1 (
        .clk(clk), .rst(rst1), .estado(est1), .fome(fome1), .sono(sono1),
        .felicidade(felic1), .morto(morto1), .ocupado(ocup1), .atualizado(atu1));

    escalonador_necessidades #(.CLK_HZ(CLKS), .VALOR_INICIAL(3)) u2 (
        .clk(clk), .rst(rst2), .estado(est2), .fome(fome2), .sono(sono2),
        .felicidade(felic2), .morto(morto2), .ocupado(ocup2), .atualizado(atu2));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] upd(input logic [7:0] v, input bit g);
        int r;
        if (g) r = (int'(v) + 5 > 255) ? 255 : int'(v) + 5;
        else   r = (int'(v) < 1) ? 0 : int'(v) - 1;
        return 8'(r);
    endfunction

    function automatic bit get_atu(input int which);
        return (which == 0) ? atu0 : (which == 1) ? atu1 : atu2;
    endfunction

    // Scoreboard for u0: model prescaler predicts each pass, result checked at atualizado.
    typedef struct {
        logic [7:0] f, s, h;
        int         cyc;
    } exp_t;
    exp_t sb[$];
    int          cyc     = 0;
    int          m_presc = 0;
    logic [7:0]  mf = 200, ms = 200, mh = 200;
    bit          dead    = 0;
    int          ocup_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst0) begin
            sb.delete();
            m_presc  = 0;
            mf = 200; ms = 200; mh = 200;
            dead     = 0;
            ocup_cnt = 0;
        end else begin
            if (ocup0) ocup_cnt++;
            if (atu0) begin
                if (sb.size() == 0) begin
                    chk("spurious_atualizado", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_fome", fome0, e.f);
                    chk("sb_sono", sono0, e.s);
                    chk("sb_felic", felic0, e.h);
                    chk("sb_latency", cyc - e.cyc, 4);
                    chk("sb_ocupado_cycles", ocup_cnt, 4);
                end
                ocup_cnt = 0;
            end
            if (m_presc == CLK0 - 1 && !dead) begin
                mf = upd(mf, est0 == 3'b001);
                ms = upd(ms, est0 == 3'b010);
                mh = upd(mh, est0 == 3'b011);
                dead = (mf == 0) || (ms == 0) || (mh == 0);
                e.f = mf; e.s = ms; e.h = mh; e.cyc = cyc;
                sb.push_back(e);
            end
            m_presc = (m_presc == CLK0 - 1) ? 0 : m_presc + 1;
        end
    end

    task automatic reset0();
        rst0 = 1'b1;
        go();
        go();
        chk("rst_fome", fome0, 200);
        chk("rst_sono", sono0, 200);
        chk("rst_felic", felic0, 200);
        chk("rst_morto", morto0, 0);
        chk("rst_ocupado", ocup0, 0);
        chk("rst_atualizado", atu0, 0);
        rst0 = 1'b0;
    endtask

    task automatic wait_upd(input int which, input int n);
        int seen = 0;
        for (int i = 0; i < 130 * n && seen < n; i++) begin
            @(negedge clk);
            if (get_atu(which)) seen++;
        end
        chk("wait_atualizado", seen, n);
    endtask

    task automatic wait_ocup0();
        int found = 0;
        for (int i = 0; i < 130 && found == 0; i++) begin
            @(negedge clk);
            if (ocup0) found = 1;
        end
        chk("wait_ocupado", found, 1);
    endtask

    initial begin
        int n_oc, n_at;

        // Reset and a single decay pass.
        est0 = 3'b000;
        reset0();
        wait_upd(0, 1);
        chk("idle_fome", fome0, 199);
        chk("idle_sono", sono0, 199);
        chk("idle_felic", felic0, 199);

        // Gain on each activity code, three ticks from reset.
        for (int k = 1; k <= 3; k++) begin
            go();
            est0 = 3'(k);
            reset0();
            wait_upd(0, 3);
            chk("act_fome", fome0, (k == 1) ? 215 : 197);
            chk("act_sono", sono0, (k == 2) ? 215 : 197);
            chk("act_felic", felic0, (k == 3) ? 215 : 197);
        end
        go();
        est0 = 3'b111;
        wait_upd(0, 1);
        chk("code7_fome", fome0, 196);
        chk("morto0_alive", morto0, 0);

        // estado change mid-pass is ignored; reset mid-pass aborts.
        go();
        est0 = 3'b000;
        reset0();
        wait_ocup0();
        go();
        est0 = 3'b001;
        wait_upd(0, 1);
        chk("midpass_fome", fome0, 199);
        chk("midpass_sono", sono0, 199);
        chk("midpass_felic", felic0, 199);
        wait_ocup0();
        go();
        go();
        rst0 = 1'b1;
        go();
        chk("abort_fome", fome0, 200);
        chk("abort_sono", sono0, 200);
        chk("abort_felic", felic0, 200);
        chk("abort_ocupado", ocup0, 0);
        chk("abort_atualizado", atu0, 0);
        rst0 = 1'b0;
        repeat (6) go();

        // Saturation at STAT_MAX.
        est1 = 3'b001;
        go();
        rst1 = 1'b0;
        wait_upd(1, 1);
        chk("sat_fome1", fome1, 255);
        chk("sat_sono1", sono1, 252);
        chk("sat_felic1", felic1, 252);
        wait_upd(1, 1);
        chk("sat_fome2", fome1, 255);
        chk("sat_sono2", sono1, 251);
        chk("sat_morto", morto1, 0);

        // Death and freeze.
        est2 = 3'b000;
        go();
        rst2 = 1'b0;
        wait_upd(2, 3);
        chk("death_fome", fome2, 0);
        chk("death_sono", sono2, 0);
        chk("death_felic", felic2, 0);
        go();
        chk("death_morto", morto2, 1);
        n_oc = 0;
        n_at = 0;
        for (int i = 0; i < 5 * CLKS + 8; i++) begin
            @(negedge clk);
            if (ocup2) n_oc++;
            if (atu2) n_at++;
        end
        chk("dead_ocupado", n_oc, 0);
        chk("dead_atualizado", n_at, 0);
        chk("dead_fome", fome2, 0);
        chk("dead_morto", morto2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
